bin2bcd_seq_disp: RTL and testbench
===================================

Name: bin2bcd_seq_disp

Overview:
- Sequential binary-to-decimal display stage. Sits directly downstream of the combinational arithmetic stage that computes (a^2)+(b*c).
- Takes that stage's 7-bit binary result and converts it to BCD with an iterative shift-add-3 (double-dabble) engine, one bit per clock.
- Registers the decimal digits and drives active-low 7-segment codes for the HEX displays, so the result shows in decimal instead of raw nibbles.

Parameters:
- WIDTH, 7: width of binary input bin.
- DIGITS, 3: number of BCD digits and segment outputs produced. Legal only when 10^DIGITS > 2^WIDTH-1.

Ports:
- CLOCK_50  input  1  system clock; all state updates on its rising edge.
- RST_N  input  1  reset, synchronous, active-low.
- start  input  1  request conversion of bin; sampled only in IDLE.
- bin  input  WIDTH  unsigned binary value, captured on the accepted start.
- busy  output  1  high while in SHIFT or DONE.
- done  output  1  one-cycle pulse when bcd/seg update.
- bcd  output  4*DIGITS  registered BCD result; digit 0 in [3:0].
- seg  output  8*DIGITS  registered active-low segment codes; digit 0 in [7:0].

Behaviour:
- One clock. Reset is synchronous and active-low: RST_N low at a rising edge forces the reset state; no asynchronous path.
- Reset values:
  - state = IDLE, busy = 0, done = 0, bcd = 0.
  - seg = 8'hC0 in every digit, so the display shows "0".
  - Internal shift register and counter = 0.
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - start = 1 at an edge loads the shift register with {4*DIGITS zeros, bin}, sets count = WIDTH, moves to SHIFT.
  - start = 0: stay in IDLE.
- SHIFT, once per cycle:
  - First, every BCD nibble >= 5 gets +3 (all nibbles corrected in parallel, combinationally).
  - Then the whole register shifts left by 1 and count decrements.
  - When count = 1 at the edge (last shift), move to DONE.
- DONE, one cycle:
  - bcd <= BCD field of the shift register; seg <= per-digit segment encoding; done = 1.
  - Next state is IDLE.
- Latency: start sampled at edge 0 -> done high during the cycle after edge WIDTH+1 (WIDTH shift edges + 1 DONE edge). Throughput is one conversion per WIDTH+2 cycles.
- bcd and seg hold their last value between conversions. They change only on the DONE edge.
- start while busy (SHIFT or DONE) is ignored and not queued.
- start held high continuously: a new conversion is accepted on the first IDLE cycle after DONE.
- bin is sampled only at the accepting edge. Later changes to bin do not affect the conversion in progress.
- Reset mid-conversion: abort, return to reset values above; no done pulse is emitted.
- Segment map, per digit: 0 C0, 1 F9, 2 A4, 3 B0, 4 99, 5 92, 6 82, 7 F8, 8 80, 9 90. Any nibble > 9 is illegal; drive FF.
- Arithmetic: unsigned only. Because 10^DIGITS > 2^WIDTH-1, no overflow can occur.

Optional Feature:
- Macro: BIN2BCD_LEADING_BLANK_EN.
- Defined:
  - Leading zero digits display 8'hFF (blank), scanning from the most significant digit down.
  - The least-significant digit is never blanked, so 0 shows as a single "0".
  - bcd is unaffected.
- Undefined: every digit shows its numeral, including leading zeros.

Test Plan:
- Reset, then bin = 0, start pulse -> done pulses exactly 8 cycles after the start edge (WIDTH = 7); bcd = 12'h000; seg = {C0, C0, C0}; busy high for 8 cycles.
- bin = 98 (7^2 + 7*7) -> bcd = 12'h098; seg = {C0, 90, 80}. With BIN2BCD_LEADING_BLANK_EN: seg = {FF, 90, 80}.
- bin = 127 -> bcd = 12'h127; seg = {F9, A4, F8}. With the macro: unchanged.
- Start bin = 55; on cycle 3 pulse start with bin = 10 -> second start ignored; result bcd = 12'h055; exactly one done pulse.
- Start bin = 99; drive RST_N low on cycle 4 -> no done pulse; bcd = 0, seg = {C0, C0, C0}, busy = 0 on the next edge. Then start bin = 5 -> bcd = 12'h005.
- start held high, bin = 1 then bin = 2 -> consecutive done pulses 9 cycles apart; bcd = 12'h001, then 12'h002.

Source files
------------

// File: rtl/bin2bcd_seq_disp_if.sv
// bin2bcd_seq_disp_if: conversion request and decimal/segment result bundle
interface bin2bcd_seq_disp_if #(
  parameter int WIDTH  = 7,
  parameter int DIGITS = 3
);
  logic                start;
  logic [WIDTH-1:0]    bin;
  logic                busy;
  logic                done;
  logic [4*DIGITS-1:0] bcd;
  logic [8*DIGITS-1:0] seg;
  modport master (output start, bin, input busy, done, bcd, seg);
  modport slave  (input start, bin, output busy, done, bcd, seg);
endinterface

// File: rtl/bin2bcd_seq_disp.sv
// bin2bcd_seq_disp: iterative double-dabble binary-to-BCD with registered 7-segment outputs
// Define BIN2BCD_LEADING_BLANK_EN to blank leading zero digits on the display.
module bin2bcd_seq_disp #(
  parameter int WIDTH  = 7,
  parameter int DIGITS = 3
) (
  input logic               CLOCK_50,
  input logic               RST_N,
  bin2bcd_seq_disp_if.slave io
);
  localparam int SW = WIDTH + 4*DIGITS;
  localparam int CW = $clog2(WIDTH+1);
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  state_t              state, state_nx;
  logic [SW-1:0]       sr, sr_adj;
  logic [CW-1:0]       cnt;
  logic [4*DIGITS-1:0] digits;
  logic [8*DIGITS-1:0] seg_nx;
  function automatic logic [7:0] enc(input logic [3:0] n);
    case (n)
      4'd0: enc = 8'hC0;
      4'd1: enc = 8'hF9;
      4'd2: enc = 8'hA4;
      4'd3: enc = 8'hB0;
      4'd4: enc = 8'h99;
      4'd5: enc = 8'h92;
      4'd6: enc = 8'h82;
      4'd7: enc = 8'hF8;
      4'd8: enc = 8'h80;
      4'd9: enc = 8'h90;
      default: enc = 8'hFF;
    endcase
  endfunction
  assign digits  = sr[SW-1:WIDTH];
  assign io.busy = state != IDLE;
  always_ff @(posedge CLOCK_50)
    state <= !RST_N ? IDLE : state_nx;
  always_comb begin
    state_nx = state == IDLE  ? (io.start ? SHIFT : IDLE) :
               state == SHIFT ? (cnt == CW'(1) ? DONE : SHIFT) : IDLE;
  end
  // add-3 correction on every digit happens before the shift of the same cycle
  always_comb begin
    sr_adj = sr;
    for (int i = 0; i < DIGITS; i++)
      sr_adj[WIDTH+4*i +: 4] = sr[WIDTH+4*i +: 4] >= 4'd5 ? sr[WIDTH+4*i +: 4] + 4'd3
                                                          : sr[WIDTH+4*i +: 4];
  end
`ifdef BIN2BCD_LEADING_BLANK_EN
  logic lead;
  always_comb begin
    seg_nx = '1;
    lead   = 1'b1;
    for (int i = DIGITS-1; i >= 0; i--) begin
      lead = lead && i > 0 && digits[4*i +: 4] == 4'd0;
      seg_nx[8*i +: 8] = lead ? 8'hFF : enc(digits[4*i +: 4]);
    end
  end
`else
  always_comb begin
    seg_nx = '1;
    for (int i = 0; i < DIGITS; i++)
      seg_nx[8*i +: 8] = enc(digits[4*i +: 4]);
  end
`endif
  always_ff @(posedge CLOCK_50) begin
    if (!RST_N) begin
      sr      <= '0;
      cnt     <= '0;
      io.done <= 1'b0;
      io.bcd  <= '0;
      io.seg  <= {DIGITS{8'hC0}};
    end else begin
      io.done <= state == DONE;
      if (state == IDLE && io.start) begin
        sr  <= {{4*DIGITS{1'b0}}, io.bin};
        cnt <= CW'(WIDTH);
      end else if (state == SHIFT) begin
        sr  <= sr_adj << 1;
        cnt <= cnt - 1'b1;
      end
      if (state == DONE) begin
        io.bcd <= digits;
        io.seg <= seg_nx;
      end
    end
  end
endmodule

// File: tb/tb_bin2bcd_seq_disp.sv
// tb_bin2bcd_seq_disp: scoreboard bench with a decimal reference model and random traffic
module tb_bin2bcd_seq_disp;
  localparam int WIDTH = 7, DIGITS = 3, LAT = WIDTH + 1;
  logic CLOCK_50, RST_N;
  bin2bcd_seq_disp_if #(.WIDTH(WIDTH), .DIGITS(DIGITS)) io ();
  bin2bcd_seq_disp #(.WIDTH(WIDTH), .DIGITS(DIGITS)) dut (
    .CLOCK_50(CLOCK_50),
    .RST_N   (RST_N),
    .io      (io.slave)
  );
  typedef struct {int v; int due;} exp_t;
  exp_t q[$];
  int checks = 0, failures = 0, cyc = 0, mcount = 0;
  logic rst_prev = 1'b0, armed = 1'b0;
  logic [7:0] tbl [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};
  initial begin
    CLOCK_50 = 1'b0;
    forever #5 CLOCK_50 = ~CLOCK_50;
  end
  function automatic logic [11:0] exp_bcd(input int v);
    return 12'((v / 100) * 256 + ((v / 10) % 10) * 16 + v % 10);
  endfunction
  function automatic logic [23:0] exp_seg(input int v);
    logic [23:0] s;
    int p;
    p = 1;
    for (int i = 0; i < DIGITS; i++) begin
      s[8*i +: 8] = tbl[(v / p) % 10];
`ifdef BIN2BCD_LEADING_BLANK_EN
      if (i > 0 && v < p) s[8*i +: 8] = 8'hFF;
`endif
      p = p * 10;
    end
    return s;
  endfunction
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, req, cyc);
    end
  endtask
  // reference: a start seen while idle is accepted and the result is due LAT edges later
  always @(posedge CLOCK_50) begin
    cyc++;
    rst_prev = !RST_N;
    if (!RST_N) begin
      armed  = 1'b1;
      mcount = 0;
      q.delete();
    end else if (mcount == 0 && io.start) begin
      q.push_back('{int'(io.bin), cyc + LAT});
      mcount = LAT;
    end else if (mcount > 0)
      mcount--;
  end
  always @(negedge CLOCK_50) begin
    exp_t e;
    if (armed) begin
      chk("busy", 32'(io.busy), 32'(mcount != 0));
      if (rst_prev) begin
        chk("reset_bcd", 32'(io.bcd), 32'h0);
        chk("reset_seg", 32'(io.seg), 32'hC0C0C0);
      end
      if (io.done === 1'b1) begin
        if (q.size() == 0)
          chk("unexpected_done", 32'(io.done), 32'h0);
        else begin
          e = q.pop_front();
          chk("done_cycle", 32'(cyc), 32'(e.due));
          chk("bcd", 32'(io.bcd), 32'(exp_bcd(e.v)));
          chk("seg", 32'(io.seg), 32'(exp_seg(e.v)));
        end
      end
    end
  end
  task automatic tick(input int n);
    repeat (n) @(posedge CLOCK_50);
    #1;
  endtask
  task automatic conv(input int v);
    io.start = 1'b1;
    io.bin   = 7'(v);
    tick(1);
    io.start = 1'b0;
    io.bin   = 7'($urandom);
    tick(9);
  endtask
  initial begin
    RST_N = 1'b0;
    io.start = 1'b0;
    io.bin = '0;
    tick(2);
    RST_N = 1'b1;
    tick(1);
    conv(0);
    conv(98);
    conv(127);
    io.start = 1'b1; io.bin = 7'd55; tick(1);
    io.start = 1'b0; tick(2);
    io.start = 1'b1; io.bin = 7'd10; tick(1);
    io.start = 1'b0; tick(8);
    io.start = 1'b1; io.bin = 7'd99; tick(1);
    io.start = 1'b0; tick(3);
    RST_N = 1'b0; tick(1);
    RST_N = 1'b1; tick(1);
    conv(5);
    io.start = 1'b1; io.bin = 7'd1; tick(1);
    io.bin = 7'd2; tick(9);
    io.start = 1'b0; tick(10);
    repeat (40) begin
      io.start = 1'b1;
      io.bin = 7'($urandom_range(0, 127));
      tick(1);
      io.start = 1'b0;
      repeat ($urandom_range(0, 12)) begin
        io.start = 1'($urandom);
        io.bin = 7'($urandom);
        tick(1);
      end
    end
    io.start = 1'b0;
    tick(12);
    chk("pending_results", 32'(q.size()), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
